// File: rtl/wakeup_array.sv
// Issue-queue wakeup array: tracks operand readiness of dispatched micro-ops,
// requests issue for fully-ready rows and releases the row granted by select.
module wakeup_array #(
   parameter int unsigned NUM_ROWS  = 16,
   parameter int unsigned TAG_W     = 6,
   parameter int unsigned NUM_WB    = 2,
   parameter int unsigned PAYLOAD_W = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           alloc_valid,
   output logic                           alloc_ready,
   input  logic [TAG_W-1:0]               alloc_src1_tag,
   input  logic                           alloc_src1_rdy,
   input  logic [TAG_W-1:0]               alloc_src2_tag,
   input  logic                           alloc_src2_rdy,
   input  logic [PAYLOAD_W-1:0]           alloc_payload,
   input  logic [NUM_WB-1:0]              wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]        wb_tag,
   output logic [NUM_ROWS-1:0]            request_vector,
   input  logic [NUM_ROWS-1:0]            select_vector,
   output logic                           issue_valid,
   output logic [PAYLOAD_W-1:0]           issue_payload,
   output logic [$clog2(NUM_ROWS+1)-1:0]  occupancy
);

   localparam int unsigned OCC_W = $clog2(NUM_ROWS + 1);
   localparam int unsigned IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   logic [NUM_ROWS-1:0]  valid_q, valid_d;
   logic [NUM_ROWS-1:0]  rdy1_q, rdy1_d;
   logic [NUM_ROWS-1:0]  rdy2_q, rdy2_d;
   logic [TAG_W-1:0]     tag1_q [NUM_ROWS];
   logic [TAG_W-1:0]     tag1_d [NUM_ROWS];
   logic [TAG_W-1:0]     tag2_q [NUM_ROWS];
   logic [TAG_W-1:0]     tag2_d [NUM_ROWS];
   logic [PAYLOAD_W-1:0] payload_q [NUM_ROWS];
   logic [PAYLOAD_W-1:0] payload_d [NUM_ROWS];

   logic                 issue_valid_q, issue_valid_d;
   logic [PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;
   logic [OCC_W-1:0]     occ_q, occ_d;

   logic                 grant_found;
   logic [IDX_W-1:0]     grant_idx;
   logic                 free_found;
   logic [IDX_W-1:0]     free_idx;
   logic                 alloc_fire;

   // True when any valid writeback port broadcasts the given tag.
   function automatic logic wb_match(input logic [TAG_W-1:0]        tag,
                                     input logic [NUM_WB-1:0]       vld,
                                     input logic [NUM_WB*TAG_W-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   assign request_vector = valid_q & rdy1_q & rdy2_q;
   assign alloc_ready    = ~&valid_q;
   assign issue_valid    = issue_valid_q;
   assign issue_payload  = issue_payload_q;
   assign occupancy      = occ_q;

   // Lowest requesting grant and lowest free row, both from start-of-cycle state.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (!grant_found && select_vector[i] && request_vector[i]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(i);
         end
         if (!free_found && !valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      alloc_fire = alloc_valid && free_found;
   end

   always_comb begin
      valid_d         = valid_q;
      rdy1_d          = rdy1_q;
      rdy2_d          = rdy2_q;
      tag1_d          = tag1_q;
      tag2_d          = tag2_q;
      payload_d       = payload_q;
      issue_valid_d   = 1'b0;
      issue_payload_d = issue_payload_q;
      occ_d           = occ_q;

      for (int i = 0; i < NUM_ROWS; i++) begin
         if (valid_q[i]) begin
            rdy1_d[i] = rdy1_q[i] | wb_match(tag1_q[i], wb_valid, wb_tag);
            rdy2_d[i] = rdy2_q[i] | wb_match(tag2_q[i], wb_valid, wb_tag);
         end
      end

      if (grant_found) begin
         valid_d[grant_idx] = 1'b0;
         issue_valid_d      = 1'b1;
         issue_payload_d    = payload_q[grant_idx];
      end

      // Dispatch bypass: a tag broadcast this cycle is captured as ready.
      if (alloc_fire) begin
         valid_d[free_idx]   = 1'b1;
         tag1_d[free_idx]    = alloc_src1_tag;
         tag2_d[free_idx]    = alloc_src2_tag;
         rdy1_d[free_idx]    = alloc_src1_rdy | wb_match(alloc_src1_tag, wb_valid, wb_tag);
         rdy2_d[free_idx]    = alloc_src2_rdy | wb_match(alloc_src2_tag, wb_valid, wb_tag);
         payload_d[free_idx] = alloc_payload;
      end

      occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(grant_found);

      if (flush) begin
         valid_d       = '0;
         issue_valid_d = 1'b0;
         occ_d         = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q         <= '0;
         rdy1_q          <= '0;
         rdy2_q          <= '0;
         issue_valid_q   <= 1'b0;
         issue_payload_q <= '0;
         occ_q           <= '0;
      end else begin
         valid_q         <= valid_d;
         rdy1_q          <= rdy1_d;
         rdy2_q          <= rdy2_d;
         issue_valid_q   <= issue_valid_d;
         issue_payload_q <= issue_payload_d;
         occ_q           <= occ_d;
      end
   end

   // Tags and payloads are only meaningful while the row is valid.
   always_ff @(posedge clk) begin
      tag1_q    <= tag1_d;
      tag2_q    <= tag2_d;
      payload_q <= payload_d;
   end

   a_select_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(select_vector));

endmodule

// File: tb/tb_wakeup_array.sv
// Self-checking bench for wakeup_array: directed scenarios followed by a
// randomized run, all compared against a row-level behavioural model.
module tb_wakeup_array;

   localparam int unsigned NUM_ROWS  = 16;
   localparam int unsigned TAG_W     = 6;
   localparam int unsigned NUM_WB    = 2;
   localparam int unsigned PAYLOAD_W = 32;
   localparam int unsigned OCC_W     = $clog2(NUM_ROWS + 1);

   logic                    clk = 1'b0;
   logic                    rst, flush, alloc_valid, alloc_ready;
   logic [TAG_W-1:0]        alloc_src1_tag, alloc_src2_tag;
   logic                    alloc_src1_rdy, alloc_src2_rdy;
   logic [PAYLOAD_W-1:0]    alloc_payload;
   logic [NUM_WB-1:0]       wb_valid;
   logic [NUM_WB*TAG_W-1:0] wb_tag;
   logic [NUM_ROWS-1:0]     request_vector, select_vector;
   logic                    issue_valid;
   logic [PAYLOAD_W-1:0]    issue_payload;
   logic [OCC_W-1:0]        occupancy;

   always #5 clk = ~clk;

   wakeup_array #(
      .NUM_ROWS(NUM_ROWS), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .PAYLOAD_W(PAYLOAD_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_src1_tag(alloc_src1_tag), .alloc_src1_rdy(alloc_src1_rdy),
      .alloc_src2_tag(alloc_src2_tag), .alloc_src2_rdy(alloc_src2_rdy),
      .alloc_payload(alloc_payload),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .request_vector(request_vector), .select_vector(select_vector),
      .issue_valid(issue_valid), .issue_payload(issue_payload),
      .occupancy(occupancy)
   );

   typedef struct {
      logic                 valid;
      logic [TAG_W-1:0]     t1;
      logic                 r1;
      logic [TAG_W-1:0]     t2;
      logic                 r2;
      logic [PAYLOAD_W-1:0] pl;
   } row_t;

   row_t                 m_rows [NUM_ROWS];
   logic                 m_iv;
   logic [PAYLOAD_W-1:0] m_ip;
   int                   checks = 0;
   int                   errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_ROWS-1:0] m_req();
      logic [NUM_ROWS-1:0] r;
      for (int i = 0; i < NUM_ROWS; i++) r[i] = m_rows[i].valid && m_rows[i].r1 && m_rows[i].r2;
      return r;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < NUM_ROWS; i++) if (m_rows[i].valid) n++;
      return n;
   endfunction

   function automatic logic m_hit(input logic [TAG_W-1:0] t);
      for (int k = 0; k < NUM_WB; k++)
         if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outputs();
      check("request_vector", 64'(request_vector), 64'(m_req()));
      check("alloc_ready",    64'(alloc_ready),    64'(m_count() < NUM_ROWS));
      check("occupancy",      64'(occupancy),      64'(m_count()));
      check("issue_valid",    64'(issue_valid),    64'(m_iv));
      check("issue_payload",  64'(issue_payload),  64'(m_ip));
   endtask

   // Advance the model by one cycle using the inputs currently driven.
   task automatic model_update();
      row_t                nxt [NUM_ROWS];
      logic [NUM_ROWS-1:0] req;
      int                  gi, fi;
      req = m_req();
      gi  = -1;
      fi  = -1;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (select_vector[i] && req[i]) gi = i;
         if (!m_rows[i].valid) fi = i;
      end
      nxt = m_rows;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (m_rows[i].valid) begin
            if (m_hit(m_rows[i].t1)) nxt[i].r1 = 1'b1;
            if (m_hit(m_rows[i].t2)) nxt[i].r2 = 1'b1;
         end
      end
      m_iv = 1'b0;
      if (gi >= 0) begin
         nxt[gi].valid = 1'b0;
         m_iv          = 1'b1;
         m_ip          = m_rows[gi].pl;
      end
      if (alloc_valid && fi >= 0) begin
         nxt[fi].valid = 1'b1;
         nxt[fi].t1    = alloc_src1_tag;
         nxt[fi].t2    = alloc_src2_tag;
         nxt[fi].r1    = alloc_src1_rdy || m_hit(alloc_src1_tag);
         nxt[fi].r2    = alloc_src2_rdy || m_hit(alloc_src2_tag);
         nxt[fi].pl    = alloc_payload;
      end
      if (flush || rst) begin
         for (int i = 0; i < NUM_ROWS; i++) nxt[i].valid = 1'b0;
         m_iv = 1'b0;
      end
      if (rst) begin
         for (int i = 0; i < NUM_ROWS; i++) begin
            nxt[i].r1 = 1'b0;
            nxt[i].r2 = 1'b0;
         end
         m_ip = '0;
      end
      m_rows = nxt;
   endtask

   task automatic clear_inputs();
      rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
      alloc_src1_tag = '0; alloc_src1_rdy = 1'b0;
      alloc_src2_tag = '0; alloc_src2_rdy = 1'b0;
      alloc_payload = '0; wb_valid = '0; wb_tag = '0; select_vector = '0;
   endtask

   task automatic step();
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic set_alloc(input logic [TAG_W-1:0] t1, input logic r1,
                            input logic [TAG_W-1:0] t2, input logic r2,
                            input logic [PAYLOAD_W-1:0] pl);
      alloc_valid = 1'b1;
      alloc_src1_tag = t1; alloc_src1_rdy = r1;
      alloc_src2_tag = t2; alloc_src2_rdy = r2;
      alloc_payload = pl;
   endtask

   task automatic set_wb(input int port, input logic [TAG_W-1:0] t);
      wb_valid[port] = 1'b1;
      wb_tag[port*TAG_W +: TAG_W] = t;
   endtask

   initial begin
      logic [NUM_ROWS-1:0] req;
      int                  cand [$];

      for (int i = 0; i < NUM_ROWS; i++) m_rows[i] = '{1'b0, '0, 1'b0, '0, 1'b0, '0};
      m_iv = 1'b0;
      m_ip = '0;

      // Reset
      clear_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      model_update();
      @(posedge clk); #1;
      clear_inputs();
      check("rst_request", 64'(request_vector), 64'h0);
      check("rst_alloc_ready", 64'(alloc_ready), 64'h1);
      check("rst_occupancy", 64'(occupancy), 64'h0);
      check("rst_issue_valid", 64'(issue_valid), 64'h0);
      check("rst_issue_payload", 64'(issue_payload), 64'h0);

      // Basic alloc -> request -> select -> issue
      set_alloc(6'd1, 1'b1, 6'd2, 1'b1, 32'hA5);
      step();
      check("t1_request", 64'(request_vector), 64'h0001);
      select_vector = 16'h0001;
      step();
      check("t1_issue_valid", 64'(issue_valid), 64'h1);
      check("t1_issue_payload", 64'(issue_payload), 64'hA5);
      check("t1_occupancy", 64'(occupancy), 64'h0);
      step();

      // Wakeup latency and non-matching tag
      set_alloc(6'd5, 1'b0, 6'd7, 1'b1, 32'h55);
      step();
      set_wb(0, 6'd6);
      step();
      check("t2_wrong_tag", 64'(request_vector), 64'h0);
      set_wb(0, 6'd5);
      check("t2_cycle_n", 64'(request_vector), 64'h0);
      step();
      check("t2_cycle_n1", 64'(request_vector), 64'h0001);
      select_vector = 16'h0001;
      step();
      step();

      // Dispatch bypass on wb port 1
      set_alloc(6'd3, 1'b1, 6'd9, 1'b0, 32'h99);
      set_wb(1, 6'd9);
      step();
      check("t3_bypass", 64'(request_vector), 64'h0001);
      select_vector = 16'h0001;
      step();
      step();

      // Fill, overflow, free-and-alloc same cycle, reuse next cycle
      for (int i = 0; i < NUM_ROWS; i++) begin
         set_alloc(6'(i), 1'b1, 6'(i + 1), 1'b1, 32'h100 + 32'(i));
         step();
      end
      check("t4_full_ready", 64'(alloc_ready), 64'h0);
      check("t4_full_occ", 64'(occupancy), 64'd16);
      set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'hDEAD);
      step();
      check("t4_overflow_occ", 64'(occupancy), 64'd16);
      select_vector = 16'h0008;
      set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'h333);
      step();
      check("t4_freed_occ", 64'(occupancy), 64'd15);
      check("t4_freed_req", 64'(request_vector), 64'hFFF7);
      check("t4_freed_payload", 64'(issue_payload), 64'h103);
      set_alloc(6'd0, 1'b1, 6'd0, 1'b1, 32'h444);
      step();
      check("t4_reuse_req", 64'(request_vector), 64'hFFFF);
      select_vector = 16'h0008;
      step();
      check("t4_reuse_payload", 64'(issue_payload), 64'h444);
      flush = 1'b1;
      step();

      // Grant to a non-requesting row is ignored
      set_alloc(6'd1, 1'b1, 6'd1, 1'b1, 32'h10); step();
      set_alloc(6'd1, 1'b1, 6'd1, 1'b1, 32'h11); step();
      set_alloc(6'd20, 1'b0, 6'd1, 1'b1, 32'h12); step();
      select_vector = 16'h0004;
      step();
      check("t5_no_issue", 64'(issue_valid), 64'h0);
      check("t5_occ", 64'(occupancy), 64'd3);
      flush = 1'b1;
      step();

      // Flush beats simultaneous alloc and select
      for (int i = 0; i < 8; i++) begin
         set_alloc(6'(i), 1'b1, 6'(i), 1'b1, 32'h200 + 32'(i));
         step();
      end
      check("t6_pre_occ", 64'(occupancy), 64'd8);
      flush = 1'b1;
      select_vector = 16'h0001;
      set_alloc(6'd1, 1'b1, 6'd1, 1'b1, 32'hBAD);
      step();
      check("t6_occ", 64'(occupancy), 64'h0);
      check("t6_req", 64'(request_vector), 64'h0);
      check("t6_issue_valid", 64'(issue_valid), 64'h0);
      check("t6_alloc_ready", 64'(alloc_ready), 64'h1);

      // Randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 99) < 60)
            set_alloc(6'($urandom_range(0, 15)), 1'($urandom_range(0, 99) < 30),
                      6'($urandom_range(0, 15)), 1'($urandom_range(0, 99) < 30),
                      32'($urandom));
         for (int k = 0; k < NUM_WB; k++)
            if ($urandom_range(0, 99) < 50) set_wb(k, 6'($urandom_range(0, 15)));
         req = m_req();
         cand.delete();
         for (int i = 0; i < NUM_ROWS; i++) if (req[i]) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(0, 99) < 60)
            select_vector = NUM_ROWS'(1) << cand[$urandom_range(0, cand.size() - 1)];
         else if ($urandom_range(0, 99) < 15)
            select_vector = NUM_ROWS'(1) << $urandom_range(0, NUM_ROWS - 1);
         if ($urandom_range(0, 99) < 2) flush = 1'b1;
         if ($urandom_range(0, 199) < 1) rst = 1'b1;
         step();
      end
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wakeup_array.md
Name: wakeup_array

Overview:
- Wakeup end of the Wakeup/Select handshake in the issue stage. Holds NUM_ROWS dispatched micro-ops.
- Snoops writeback tag broadcasts to mark source operands ready, and drives request_vector for every row whose sources are all ready.
- Consumes select_vector from the select logic: frees the granted row and emits its payload to the issue/register-read stage.

Parameters:
- NUM_ROWS, 16, number of entries; same value as CORE_PKG::NUM_ROWS.
- TAG_W, 6, physical register tag width.
- NUM_WB, 2, number of writeback tag broadcast ports.
- PAYLOAD_W, 32, opaque micro-op payload width.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; clears all rows.
- alloc_valid  in  1  dispatch presents a micro-op.
- alloc_ready  out  1  at least one free row.
- alloc_src1_tag  in  TAG_W  source 1 tag.
- alloc_src1_rdy  in  1  source 1 already ready at dispatch.
- alloc_src2_tag  in  TAG_W  source 2 tag.
- alloc_src2_rdy  in  1  source 2 already ready at dispatch.
- alloc_payload  in  PAYLOAD_W  micro-op payload.
- wb_valid  in  NUM_WB  per-port broadcast valid.
- wb_tag  in  NUM_WB*TAG_W  broadcast tags; port k is bits [k*TAG_W +: TAG_W].
- request_vector  out  NUM_ROWS  row i ready to issue.
- select_vector  in  NUM_ROWS  grant from select; at most one bit set.
- issue_valid  out  1  registered issue strobe.
- issue_payload  out  PAYLOAD_W  payload of the granted row.
- occupancy  out  $clog2(NUM_ROWS+1)  count of valid rows.

Behaviour:
- Per-row state: valid, src1_tag, src1_rdy, src2_tag, src2_rdy, payload.
- Reset: all valid=0, ready bits=0, issue_valid=0, issue_payload=0, occupancy=0. Consequently request_vector=0 and alloc_ready=1.
- request_vector[i] = valid[i] & src1_rdy[i] & src2_rdy[i]. This is combinational from registered state only; there is no combinational path from wb_* or alloc_* to request_vector.
- alloc_ready = ~&valid, computed from state at the start of the cycle.
- Allocation:
  - Fires when alloc_valid & alloc_ready. The lowest-index row with valid=0 is written at the clock edge.
  - A row freed by select in the same cycle is not reusable until the next cycle.
  - alloc_valid while full is ignored, with no state change.
- Wakeup:
  - For each valid row and each source, if any port k has wb_valid[k] and wb_tag[k]==src_tag, set src_rdy at the edge.
  - Wakeup latency: broadcast in cycle N gives request_vector asserted in cycle N+1.
  - Dispatch bypass: when an allocated source tag matches a broadcast in the same cycle, it is written with rdy=1 regardless of alloc_srcX_rdy.
  - Already-ready sources are unaffected by broadcasts.
- Select:
  - If select_vector has bit i set and request_vector[i]=1 in cycle N, then in N+1: valid[i]=0, issue_valid=1, issue_payload=payload[i].
  - Otherwise issue_valid=0 in N+1 and issue_payload holds its previous value.
  - A grant to a non-requesting row is ignored (no free, no issue).
  - A multi-hot select_vector is an error, flagged by a simulation assertion. RTL honours only the lowest set bit that is requesting.
- occupancy updates with +1 on alloc, -1 on issue. Simultaneous alloc and issue leaves it unchanged.
- Flush:
  - Takes priority over alloc, select and wakeup in the same cycle.
  - Next cycle: all valid=0, occupancy=0, issue_valid=0.
- Reset mid-operation is identical to flush plus issue_payload cleared to 0.
- Ready bits of invalid rows are don't-care but must never raise request_vector.

Test Plan:
- Reset, then alloc src1_rdy=1, src2_rdy=1, payload 0xA5 -> row0 valid, request_vector=0x0001 next cycle; select_vector=0x0001 -> issue_valid=1, issue_payload=0xA5 one cycle later, occupancy back to 0.
- Alloc row0 with src1_tag=5 not ready; wb_valid=01, wb_tag[0]=5 in cycle N -> request_vector[0]=0 in N, =1 in N+1; wb tag 6 leaves it 0.
- Alloc with src2_tag=9 not ready while wb port 1 broadcasts tag 9 in the same cycle -> row requests the very next cycle (bypass).
- Fill all 16 rows -> alloc_ready=0, occupancy=16; extra alloc_valid ignored. Select row3 and alloc in the same cycle -> allocation does not take row3 that cycle; row3 is reused the following cycle.
- select_vector=0x0004 with row2 not ready -> no free, issue_valid=0, occupancy unchanged.
- 8 rows valid, flush asserted with simultaneous alloc and select -> next cycle occupancy=0, request_vector=0, issue_valid=0, alloc_ready=1.
